// File: rtl/ft232h_ram_arbiter_if.sv
// Bus bundle between the two FT232H byte paths, the arbiter and the single-port RAM.
interface ft232h_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              a_req, a_write, a_lock, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_write, b_lock, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_write, ram_clken;
  logic [DATA_W-1:0] ram_writedata, ram_readdata;

  modport slave (
    input  a_req, a_write, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_write, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken,
    input  ram_readdata
  );

  modport master (
    output a_req, a_write, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_write, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_address, ram_chipselect, ram_write, ram_writedata, ram_clken,
    output ram_readdata
  );
endinterface

// File: rtl/ft232h_ram_arbiter.sv
// Two-requester RAM arbiter: round-robin on conflict, optional locked bursts capped at MAX_BURST.
module ft232h_ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ft232h_ram_arbiter_if.slave  bus
);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;    // 1 = B was granted last
  logic [7:0]        bcnt_q, bcnt_d;
  logic              gnt_a, gnt_b, own_cont, idle_a, idle_b, issue;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rv_a_q, rv_b_q, clken_q;

  assign idle_a = bus.a_req & (~bus.b_req | last_q);
  assign idle_b = bus.b_req & (~bus.a_req | ~last_q);
  assign issue  = gnt_a | gnt_b;

  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    own_cont = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    bcnt_d   = bcnt_q;
    if (!reset) begin
      // An owner keeps the RAM until its burst is used up, unless nobody else wants it.
      case (state_q)
        OWN_A: begin
          if (bus.a_req && (bcnt_q < MAXB || !bus.b_req)) begin
            gnt_a    = 1'b1;
            own_cont = 1'b1;
          end else begin
            gnt_a = idle_a;
            gnt_b = idle_b;
          end
        end
        OWN_B: begin
          if (bus.b_req && (bcnt_q < MAXB || !bus.a_req)) begin
            gnt_b    = 1'b1;
            own_cont = 1'b1;
          end else begin
            gnt_a = idle_a;
            gnt_b = idle_b;
          end
        end
        default: begin
          gnt_a = idle_a;
          gnt_b = idle_b;
        end
      endcase

      if (gnt_a || gnt_b) begin
        last_d = gnt_b;
        // Saturated owner with an idle rival restarts its burst rather than wrapping.
        bcnt_d = (own_cont && bcnt_q < MAXB) ? bcnt_q + 8'd1 : 8'd1;
        if (gnt_a) state_d = bus.a_lock ? OWN_A : IDLE;
        else       state_d = bus.b_lock ? OWN_B : IDLE;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv_a_q  <= 1'b0;
      rv_b_q  <= 1'b0;
      clken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      rv_a_q  <= gnt_a & ~bus.a_write;
      rv_b_q  <= gnt_b & ~bus.b_write;
      clken_q <= 1'b1;
      if (issue) begin
        addr_q  <= bus.ram_address;
        wdata_q <= bus.ram_writedata;
      end
    end
  end

  assign bus.a_gnt          = gnt_a;
  assign bus.b_gnt          = gnt_b;
  assign bus.a_rvalid       = rv_a_q;
  assign bus.b_rvalid       = rv_b_q;
  assign bus.a_rdata        = bus.ram_readdata;
  assign bus.b_rdata        = bus.ram_readdata;
  assign bus.ram_chipselect = issue;
  assign bus.ram_write      = (gnt_a & bus.a_write) | (gnt_b & bus.b_write);
  assign bus.ram_address    = gnt_a ? bus.a_addr  : gnt_b ? bus.b_addr  : addr_q;
  assign bus.ram_writedata  = gnt_a ? bus.a_wdata : gnt_b ? bus.b_wdata : wdata_q;
  assign bus.ram_clken      = clken_q;
endmodule

// File: tb/tb_ft232h_ram_arbiter.sv
// Directed vector bench for ft232h_ram_arbiter with a behavioural byte RAM behind it.
module tb_ft232h_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ft232h_ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  ft232h_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (bus.ram_chipselect) begin
      if (bus.ram_write) mem[bus.ram_address] <= bus.ram_writedata;
      else               rd_q <= mem[bus.ram_address];
    end
  end
  assign bus.ram_readdata = rd_q;

  typedef struct {
    logic ar, aw, al; logic [15:0] aa; logic [7:0] ad;
    logic br, bw, bl; logic [15:0] ba; logic [7:0] bd;
    logic ag, bg, cs, wr; logic [15:0] addr; logic [7:0] wd;
    logic arv, brv, chk; logic [7:0] rd;
  } vec_t;

  vec_t vecs [23];
  int total = 0;
  int bad   = 0;

  task automatic drive(input logic ar, aw, al, input logic [15:0] aa, input logic [7:0] ad,
                       input logic br, bw, bl, input logic [15:0] ba, input logic [7:0] bd);
    bus.a_req = ar; bus.a_write = aw; bus.a_lock = al; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_write = bw; bus.b_lock = bl; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  function automatic logic [30:0] snap();
    return {bus.a_gnt, bus.b_gnt, bus.ram_chipselect, bus.ram_write, bus.ram_address,
            bus.ram_writedata, bus.a_rvalid, bus.b_rvalid, bus.ram_clken};
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // inputs: A{req,wr,lock,addr,wdata} B{...}; expected: a_gnt b_gnt cs wr addr wdata a_rv b_rv chk rdata
    vecs[0]  = '{0,0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0000,8'h00, 0,0,0,8'h00};
    vecs[1]  = '{1,1,0,16'h1234,8'h5A, 0,0,0,16'h0000,8'h00, 1,0,1,1,16'h1234,8'h5A, 0,0,0,8'h00};
    vecs[2]  = '{0,0,0,16'h0000,8'h00, 1,0,0,16'h1234,8'h00, 0,1,1,0,16'h1234,8'h00, 0,0,0,8'h00};
    vecs[3]  = '{0,0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 0,0,0,0,16'h1234,8'h00, 0,1,1,8'h5A};
    vecs[4]  = '{0,0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 0,0,0,0,16'h1234,8'h00, 0,0,0,8'h00};
    // both reading, no lock: strict alternation starting with A
    vecs[5]  = '{1,0,0,16'h0010,8'h00, 1,0,0,16'h0020,8'h00, 1,0,1,0,16'h0010,8'h00, 0,0,0,8'h00};
    vecs[6]  = '{1,0,0,16'h0010,8'h00, 1,0,0,16'h0020,8'h00, 0,1,1,0,16'h0020,8'h00, 1,0,0,8'h00};
    vecs[7]  = '{1,0,0,16'h0010,8'h00, 1,0,0,16'h0020,8'h00, 1,0,1,0,16'h0010,8'h00, 0,1,0,8'h00};
    vecs[8]  = '{1,0,0,16'h0010,8'h00, 1,0,0,16'h0020,8'h00, 0,1,1,0,16'h0020,8'h00, 1,0,0,8'h00};
    vecs[9]  = '{0,0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0020,8'h00, 0,1,0,8'h00};
    // A locks against a busy B: 4 A grants, then B, then A again
    vecs[10] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 0,0,0,8'h00};
    vecs[11] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[12] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[13] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[14] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 0,1,1,0,16'h0040,8'h00, 1,0,0,8'h00};
    vecs[15] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 0,1,0,8'h00};
    // A alone saturates its burst, restarts at 1, so a late B must wait
    vecs[16] = '{1,0,1,16'h0030,8'h00, 0,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[17] = '{1,0,1,16'h0030,8'h00, 0,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[18] = '{1,0,1,16'h0030,8'h00, 0,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[19] = '{1,0,1,16'h0030,8'h00, 0,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    vecs[20] = '{1,0,1,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 1,0,1,0,16'h0030,8'h00, 1,0,0,8'h00};
    // owner drops its request: B is served in the same cycle
    vecs[21] = '{0,0,0,16'h0030,8'h00, 1,0,0,16'h0040,8'h00, 0,1,1,0,16'h0040,8'h00, 1,0,0,8'h00};
    vecs[22] = '{0,0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 0,0,0,0,16'h0040,8'h00, 0,1,0,8'h00};

    // reset state, with a request pending to show grants are suppressed
    drive(1,0,0,16'h1111,8'h22, 1,1,0,16'h3333,8'h44);
    repeat (3) @(negedge clk);
    #1 check("reset_state", snap(), 31'h0);
    drive(0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vecs[i].ar, vecs[i].aw, vecs[i].al, vecs[i].aa, vecs[i].ad,
            vecs[i].br, vecs[i].bw, vecs[i].bl, vecs[i].ba, vecs[i].bd);
      #1;
      check($sformatf("vec%0d", i), snap(),
            {vecs[i].ag, vecs[i].bg, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wd,
             vecs[i].arv, vecs[i].brv, 1'b1});
      if (vecs[i].chk)
        check($sformatf("vec%0d_rdata", i), {23'h0, (vecs[i].arv ? bus.a_rdata : bus.b_rdata)},
              {23'h0, vecs[i].rd});
    end

    // A read grant, then reset in the following cycle
    @(negedge clk);
    drive(1,0,0,16'h0050,8'h00, 0,0,0,16'h0000,8'h00);
    #1 check("pre_reset_gnt", {30'h0, bus.a_gnt}, 31'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check("mid_reset_outputs", snap(), 31'h0);
    @(negedge clk);
    #1 check("held_reset_outputs", snap(), 31'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1,0,0,16'h0060,8'h00, 1,0,0,16'h0070,8'h00);
    #1 check("post_reset_conflict", {29'h0, bus.a_gnt, bus.b_gnt}, 31'h2);
    check("post_reset_rvalid", {29'h0, bus.a_rvalid, bus.b_rvalid}, 31'h0);
    @(negedge clk);
    #1 check("post_reset_next", {27'h0, bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.ram_clken},
             31'h7);
    drive(0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
